avg_pool_responder: RTL and testbench

Responder side of the forward-pass go/done handshake: the averaging stage that a forward-pass controller starts with avg_go and waits on via avg_done. On avg_go it reads a binary drawing canvas from a source RAM and block-averages it into an OUT_W x OUT_H 8-bit grayscale image. It writes that image into the MLP input RAM and then pulses avg_done. Sits between the canvas frame buffer and the MLP stage.

---
 rtl/hdr_pkg.sv | 23 ++
 rtl/avg_pool_responder_addr_gen.sv | 86 ++++++++
 rtl/avg_pool_responder.sv | 130 +++++++++++++
 tb/tb_avg_pool_responder.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/hdr_pkg.sv
// Shared definitions for the averaging stage that sits between the canvas
// frame buffer and the MLP input RAM.
//   - Default image geometry (SRC_W, SRC_H, BLK, OUT_W, OUT_H)
//   - Output pixel width PIX_W
//   - FSM state encoding avg_state_t
package hdr_pkg;

  localparam int SRC_W = 224;
  localparam int SRC_H = 224;
  localparam int BLK   = 8;
  localparam int OUT_W = 28;
  localparam int OUT_H = 28;
  localparam int PIX_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    DRAIN = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } avg_state_t;

endpackage

// File: rtl/avg_pool_responder_addr_gen.sv
// avg_addr_gen: nested block/output counters and address generation.
// bx/by walk the pixels inside one BLK x BLK block (bx fastest), ox/oy walk
// the output pixels (ox fastest).
// Ports:
//   clk, reset     clock, synchronous active-high reset
//   clear          zero every counter (start of a pass)
//   step_rd        advance bx/by by one read
//   step_px        advance ox/oy by one output pixel
//   src_addr       (oy*BLK+by)*SRC_W + ox*BLK + bx
//   dst_addr       oy*OUT_W + ox
//   last_in_block  current read is the final one of the block
//   last_pixel     current output pixel is the final one of the image
module avg_addr_gen
  import hdr_pkg::*;
#(
  parameter int SRC_W  = hdr_pkg::SRC_W,
  parameter int SRC_H  = hdr_pkg::SRC_H,
  parameter int BLK    = hdr_pkg::BLK,
  parameter int OUT_W  = hdr_pkg::OUT_W,
  parameter int OUT_H  = hdr_pkg::OUT_H,
  parameter int SRC_AW = 16,
  parameter int DST_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              step_rd,
  input  logic              step_px,
  output logic [SRC_AW-1:0] src_addr,
  output logic [DST_AW-1:0] dst_addr,
  output logic              last_in_block,
  output logic              last_pixel
);

  localparam int BW  = (BLK   > 1) ? $clog2(BLK)   : 1;
  localparam int OXW = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OYW = (OUT_H > 1) ? $clog2(OUT_H) : 1;

  localparam logic [BW-1:0]  B_LAST  = BW'(BLK - 1);
  localparam logic [OXW-1:0] OX_LAST = OXW'(OUT_W - 1);
  localparam logic [OYW-1:0] OY_LAST = OYW'(OUT_H - 1);

  logic [BW-1:0]  bx, by;
  logic [OXW-1:0] ox;
  logic [OYW-1:0] oy;
  logic [31:0]    src_lin;
  logic [31:0]    dst_lin;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      bx <= '0;
      by <= '0;
      ox <= '0;
      oy <= '0;
    end else begin
      if (step_rd) begin
        if (bx == B_LAST) begin
          bx <= '0;
          by <= (by == B_LAST) ? '0 : by + 1'b1;
        end else begin
          bx <= bx + 1'b1;
        end
      end
      if (step_px) begin
        if (ox == OX_LAST) begin
          ox <= '0;
          oy <= (oy == OY_LAST) ? '0 : oy + 1'b1;
        end else begin
          ox <= ox + 1'b1;
        end
      end
    end
  end

  always_comb begin
    src_lin = (32'(oy) * BLK + 32'(by)) * SRC_W + 32'(ox) * BLK + 32'(bx);
    dst_lin = 32'(oy) * OUT_W + 32'(ox);
  end

  assign src_addr      = src_lin[SRC_AW-1:0];
  assign dst_addr      = dst_lin[DST_AW-1:0];
  assign last_in_block = (bx == B_LAST) && (by == B_LAST);
  // The last block row starts at source row SRC_H-BLK (SRC_H == OUT_H*BLK).
  assign last_pixel    = (ox == OX_LAST) && ((32'(oy) * BLK) == (SRC_H - BLK));

endmodule

// File: rtl/avg_pool_responder.sv
// avg_pool_responder: block-averages a binary canvas into an OUT_W x OUT_H
// 8-bit image and writes it to the MLP input RAM.
// Handshake: avg_go is sampled only in IDLE; avg_busy is high from the cycle
// after acceptance until avg_done; avg_done pulses for one cycle, after which
// a new avg_go is accepted. src_data is valid exactly one cycle after
// src_rd_en. dst_we and src_rd_en are never high together.
// Ports:
//   clk, reset              clock, synchronous active-high reset
//   avg_go / avg_busy / avg_done   start, in-progress, completion pulse
//   src_rd_en/src_addr/src_data    source canvas RAM read port (1-bit pixels)
//   dst_we/dst_addr/dst_data       destination RAM write port (8-bit pixels)
// Optional build macro: AVG_BINARIZE_EN -- output 255 when at least half the
// block is set, else 0, instead of the saturating grayscale scale.
module avg_pool_responder
  import hdr_pkg::*;
#(
  parameter int SRC_W  = hdr_pkg::SRC_W,
  parameter int SRC_H  = hdr_pkg::SRC_H,
  parameter int BLK    = hdr_pkg::BLK,
  parameter int OUT_W  = hdr_pkg::OUT_W,
  parameter int OUT_H  = hdr_pkg::OUT_H,
  parameter int SRC_AW = 16,
  parameter int DST_AW = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              avg_go,
  output logic              avg_busy,
  output logic              avg_done,
  output logic              src_rd_en,
  output logic [SRC_AW-1:0] src_addr,
  input  logic              src_data,
  output logic              dst_we,
  output logic [DST_AW-1:0] dst_addr,
  output logic [PIX_W-1:0]  dst_data
);

  localparam logic [2:0] S_IDLE  = IDLE;
  localparam logic [2:0] S_READ  = READ;
  localparam logic [2:0] S_DRAIN = DRAIN;
  localparam logic [2:0] S_WRITE = WRITE;
  localparam logic [2:0] S_DONE  = DONE;

  // Holds up to BLK*BLK ones without overflow.
  localparam int AW = $clog2(BLK * BLK) + 1;

  logic [2:0]        state, next_state;
  logic              rd_pending;
  logic [AW-1:0]     acc;
  logic [PIX_W-1:0]  pix;
  logic [SRC_AW-1:0] gen_src_addr;
  logic [DST_AW-1:0] gen_dst_addr;
  logic              last_in_block, last_pixel;
  logic              start;

  assign start = (state == S_IDLE) && avg_go;

  avg_addr_gen #(
    .SRC_W (SRC_W),
    .SRC_H (SRC_H),
    .BLK   (BLK),
    .OUT_W (OUT_W),
    .OUT_H (OUT_H),
    .SRC_AW(SRC_AW),
    .DST_AW(DST_AW)
  ) u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .clear        (start),
    .step_rd      (state == S_READ),
    .step_px      (state == S_WRITE),
    .src_addr     (gen_src_addr),
    .dst_addr     (gen_dst_addr),
    .last_in_block(last_in_block),
    .last_pixel   (last_pixel)
  );

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (avg_go) next_state = S_READ;
      S_READ:  if (last_in_block) next_state = S_DRAIN;
      S_DRAIN: next_state = S_WRITE;
      S_WRITE: next_state = last_pixel ? S_DONE : S_READ;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // rd_pending marks that src_data carries a pixel read last cycle. It is
  // low on the first READ cycle of every block, so that cycle adds nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending <= 1'b0;
      acc        <= '0;
    end else begin
      rd_pending <= (state == S_READ);
      if (start || (state == S_WRITE))
        acc <= '0;
      else if (rd_pending)
        acc <= acc + {{(AW-1){1'b0}}, src_data};
    end
  end

`ifdef AVG_BINARIZE_EN
  assign pix = (32'(acc) >= (BLK * BLK) / 2) ? {PIX_W{1'b1}} : '0;
`else
  // A full block (BLK*BLK) maps to 256, which saturates to 255.
  localparam int SH = 8 - 2 * $clog2(BLK);
  logic [31:0] scaled;
  assign scaled = 32'(acc) << SH;
  assign pix    = (scaled > 32'd255) ? {PIX_W{1'b1}} : scaled[PIX_W-1:0];
`endif

  // Address/data outputs are forced to zero outside their strobe cycles so
  // the ports sit at zero whenever the block is idle or in reset.
  assign avg_busy  = (state != S_IDLE);
  assign avg_done  = (state == S_DONE);
  assign src_rd_en = (state == S_READ);
  assign src_addr  = src_rd_en ? gen_src_addr : '0;
  assign dst_we    = (state == S_WRITE);
  assign dst_addr  = dst_we ? gen_dst_addr : '0;
  assign dst_data  = dst_we ? pix : '0;

endmodule

// File: tb/tb_avg_pool_responder.sv
// Bench for avg_pool_responder on a reduced geometry (BLK=4, 5x4 output).
module tb_avg_pool_responder;

  localparam int B      = 4;
  localparam int OW     = 5;
  localparam int OH     = 4;
  localparam int SW     = OW * B;
  localparam int SH     = OH * B;
  localparam int NPIX   = OW * OH;
  localparam int PASS   = 1 + NPIX * (B * B + 2);
  localparam int SAW    = 16;
  localparam int DAW    = 10;
  localparam int EW     = DAW + 8;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           avg_go = 1'b0;
  logic           avg_busy, avg_done;
  logic           src_rd_en;
  logic [SAW-1:0] src_addr;
  logic           src_data = 1'b0;
  logic           dst_we;
  logic [DAW-1:0] dst_addr;
  logic [7:0]     dst_data;

  logic           canvas [SW*SH];
  logic [EW-1:0]  exp_q [$];
  int             checks = 0;
  int             failures = 0;
  int             cyc = 0;
  int             done_cnt = 0;

  avg_pool_responder #(
    .SRC_W(SW), .SRC_H(SH), .BLK(B), .OUT_W(OW), .OUT_H(OH),
    .SRC_AW(SAW), .DST_AW(DAW)
  ) dut (
    .clk(clk), .reset(reset), .avg_go(avg_go), .avg_busy(avg_busy),
    .avg_done(avg_done), .src_rd_en(src_rd_en), .src_addr(src_addr),
    .src_data(src_data), .dst_we(dst_we), .dst_addr(dst_addr),
    .dst_data(dst_data)
  );

  // clock / reset-independent cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // source RAM model: one-cycle read latency
  always @(posedge clk)
    if (src_rd_en) src_data <= (int'(src_addr) < SW * SH) ? canvas[src_addr] : 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0d expected=%0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // scoreboard: compare every destination write against the expected queue
  always @(negedge clk) begin
    if (avg_done) done_cnt++;
    if (dst_we) begin
      logic [EW-1:0] e;
      check("rd_we_excl", 32'(src_rd_en), 0);
      check("write_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("dst_addr", 32'(dst_addr), 32'(e[EW-1:8]));
        check("dst_data", 32'(dst_data), 32'(e[7:0]));
      end
    end
  end

  // 0 zeros, 1 ones, 2 block (oy=2,ox=3) half filled, 3 checkerboard
  task automatic fill(input int pattern);
    for (int y = 0; y < SH; y++)
      for (int x = 0; x < SW; x++) begin
        logic v;
        case (pattern)
          1:       v = 1'b1;
          2:       v = (y == 2 * B || y == 2 * B + 1) && (x >= 3 * B) && (x < 4 * B);
          3:       v = logic'((x + y) % 2);
          default: v = 1'b0;
        endcase
        canvas[y * SW + x] = v;
      end
  endtask

  task automatic push_expected();
    for (int oy = 0; oy < OH; oy++)
      for (int ox = 0; ox < OW; ox++) begin
        int sum, v;
        sum = 0;
        for (int by = 0; by < B; by++)
          for (int bx = 0; bx < B; bx++)
            sum += int'(canvas[(oy * B + by) * SW + ox * B + bx]);
`ifdef AVG_BINARIZE_EN
        v = (2 * sum >= B * B) ? 255 : 0;
`else
        v = (sum * 256) / (B * B);
        if (v > 255) v = 255;
`endif
        exp_q.push_back({DAW'(oy * OW + ox), 8'(v)});
      end
  endtask

  // Run one pass. ignore_at>0: pulse avg_go at that relative cycle and in
  // the DONE cycle. reset_at>0: assert reset at that relative cycle.
  task automatic do_pass(input int pattern, input int ignore_at, input int reset_at);
    int go_cyc, rel, rd_i, done0;
    bit finished;
    fill(pattern);
    push_expected();
    done0 = done_cnt;
    rd_i = 0;
    finished = 0;
    @(negedge clk);
    avg_go = 1'b1;
    go_cyc = cyc;
    @(negedge clk);
    avg_go = 1'b0;
    check("first_rd_en", 32'(src_rd_en), 1);
    check("busy_start", 32'(avg_busy), 1);
    for (int k = 0; k < PASS + 50 && !finished; k++) begin
      rel = cyc - go_cyc;
      if (src_rd_en && rd_i < B * B) begin
        check("blk0_src_addr", 32'(src_addr), 32'((rd_i / B) * SW + rd_i % B));
        rd_i++;
      end
      if (reset_at > 0 && rel == reset_at) begin
        reset = 1'b1;
        @(negedge clk);
        check("rst_outputs",
              {13'd0, avg_busy, avg_done, src_rd_en, dst_we, src_addr != 0, dst_addr != 0, dst_data},
              0);
        check("rst_state", 32'(dut.state), 0);
        exp_q.delete();
        reset = 1'b0;
        repeat (PASS + 20) @(negedge clk);
        check("rst_no_done", 32'(done_cnt), 32'(done0));
        return;
      end
      if (avg_done) begin
        check("done_cycle", 32'(rel), 32'(PASS));
        check("busy_at_done", 32'(avg_busy), 1);
        if (ignore_at > 0) avg_go = 1'b1;
        @(negedge clk);
        avg_go = 1'b0;
        check("busy_after_done", 32'(avg_busy), 0);
        check("done_pulse_width", 32'(avg_done), 0);
        finished = 1;
      end else begin
        avg_go = (ignore_at > 0 && rel + 1 == ignore_at);
        @(negedge clk);
      end
    end
    check("pass_finished", 32'(finished), 1);
    repeat (4) @(negedge clk);
    check("all_writes_seen", 32'(exp_q.size()), 0);
    check("one_done", 32'(done_cnt - done0), 1);
    check("idle_after", 32'(avg_busy), 0);
  endtask

  initial begin
    for (int i = 0; i < SW * SH; i++) canvas[i] = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_state", 32'(dut.state), 0);
    check("reset_outputs",
          {14'd0, avg_busy, avg_done, src_rd_en, dst_we, src_addr != 0, dst_addr != 0, dst_data},
          0);
    reset = 1'b0;
    @(negedge clk);

    do_pass(0, 0, 0);                          // all zeros, latency
    do_pass(1, 0, 0);                          // all ones, saturation
    do_pass(2, 0, 0);                          // single half-filled block
    do_pass(3, 0, 0);                          // checkerboard, addressing
    do_pass(0, $urandom_range(80, 200), 0);    // ignored avg_go pulses
    do_pass(1, 0, 150);                        // reset mid-pass
    do_pass(3, 0, 0);                          // full pass after abort

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
